// File: rtl/rf_pkg.sv
// Shared types and helpers for the register-file write-enable arbiter.
// Holds the write-source encoding and the rotated index mapping.
package rf_pkg;

    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_NREG     = 2 ** DEF_ADDR_W;
    localparam int DEF_ROT      = 1;
    localparam int DEF_MAX_WAIT = 3;

    typedef enum logic [1:0] {
        WS_NONE = 2'b00,
        WS_P0   = 2'b01,
        WS_P1   = 2'b10
    } wr_src_t;

    // Register index to enable-bit position: (addr + rot) mod nreg.
    function automatic int rot_idx(
        input int addr,
        input int rot,
        input int nreg
    );
        int sum;
        sum = addr + rot;
        return sum % nreg;
    endfunction

endpackage

// File: rtl/rf_onehot_dec.sv
// Rotated index to one-hot decoder.
// Purely combinational; index i lights bit (i+ROT) mod NREG.
module rf_onehot_dec
    import rf_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREG   = 2 ** ADDR_W,
    parameter int ROT    = DEF_ROT
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [NREG-1:0]   onehot
);

    localparam int IDX_W = (NREG < 2) ? 1 : $clog2(NREG);

    logic [IDX_W-1:0] idx;

    // Map the index onto its rotated bit and set only that bit.
    always_comb begin
        idx         = IDX_W'(rot_idx(32'(addr), ROT, NREG));
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rf_wen_arb.sv
// Two-port register-file write-enable arbiter.
// ALU port has priority; the load port is parked in a one-entry hold.
module rf_wen_arb
    import rf_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NREG     = 2 ** ADDR_W,
    parameter int ROT      = DEF_ROT,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              p0_valid,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic              p0_ready,
    input  logic              p1_valid,
    input  logic [ADDR_W-1:0] p1_addr,
    output logic              p1_ready,
    input  logic [NREG-1:0]   lock_mask,
    output logic [NREG-1:0]   R_en,
    output logic [1:0]        wr_src,
    output logic              drop_err,
    output logic              hold_busy
);

    localparam int WC_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WAIT);

    logic              hold_valid_q, hold_valid_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [NREG-1:0]   r_en_q, r_en_d;
    wr_src_t           wr_src_q, wr_src_d;
    logic              drop_err_q, drop_err_d;

    logic              wait_full;
    logic              p1_xfer;
    logic              gnt_valid;
    logic              gnt_hold;
    logic              gnt_p1;
    logic [ADDR_W-1:0] gnt_addr;
    wr_src_t           gnt_src;
    logic [NREG-1:0]   gnt_onehot;
    logic              gnt_locked;

    // Readies depend only on registered hold state and en, never on valids.
    always_comb begin
        wait_full = hold_valid_q && (wait_cnt_q == WC_MAX);
        p0_ready  = en && !wait_full;
        p1_ready  = en && !hold_valid_q;
        p1_xfer   = p1_valid && p1_ready;
        hold_busy = hold_valid_q;
    end

    // Single grant per cycle: starved hold, then ALU, then hold, then load.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_hold  = 1'b0;
        gnt_p1    = 1'b0;
        gnt_addr  = '0;
        gnt_src   = WS_NONE;
        if (en) begin
            if (wait_full) begin
                gnt_valid = 1'b1;
                gnt_hold  = 1'b1;
                gnt_addr  = hold_addr_q;
                gnt_src   = WS_P1;
            end else if (p0_valid) begin
                gnt_valid = 1'b1;
                gnt_addr  = p0_addr;
                gnt_src   = WS_P0;
            end else if (hold_valid_q) begin
                gnt_valid = 1'b1;
                gnt_hold  = 1'b1;
                gnt_addr  = hold_addr_q;
                gnt_src   = WS_P1;
            end else if (p1_xfer) begin
                gnt_valid = 1'b1;
                gnt_p1    = 1'b1;
                gnt_addr  = p1_addr;
                gnt_src   = WS_P1;
            end
        end
    end

    rf_onehot_dec #(
        .ADDR_W (ADDR_W),
        .NREG   (NREG),
        .ROT    (ROT)
    ) u_dec (
        .addr   (gnt_addr),
        .onehot (gnt_onehot)
    );

    // Hold entry: drained on grant, aged while waiting, filled by a losing load.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_addr_d  = hold_addr_q;
        wait_cnt_d   = wait_cnt_q;
        if (gnt_hold) begin
            hold_valid_d = 1'b0;
            wait_cnt_d   = '0;
        end else if (hold_valid_q && en && (wait_cnt_q != WC_MAX)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if (p1_xfer && !gnt_p1) begin
            hold_valid_d = 1'b1;
            hold_addr_d  = p1_addr;
            wait_cnt_d   = '0;
        end
    end

    // Output stage: locked targets are consumed but flagged, not written.
    always_comb begin
        gnt_locked = |(gnt_onehot & lock_mask);
        r_en_d     = '0;
        wr_src_d   = WS_NONE;
        drop_err_d = 1'b0;
        if (gnt_valid) begin
            wr_src_d   = gnt_src;
            drop_err_d = gnt_locked;
            if (!gnt_locked) begin
                r_en_d = gnt_onehot;
            end
        end
    end

    // State registers; reset discards any held write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_addr_q  <= '0;
            wait_cnt_q   <= '0;
            r_en_q       <= '0;
            wr_src_q     <= WS_NONE;
            drop_err_q   <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_addr_q  <= hold_addr_d;
            wait_cnt_q   <= wait_cnt_d;
            r_en_q       <= r_en_d;
            wr_src_q     <= wr_src_d;
            drop_err_q   <= drop_err_d;
        end
    end

    assign R_en     = r_en_q;
    assign wr_src   = wr_src_q;
    assign drop_err = drop_err_q;

endmodule

// File: tb/tb_rf_wen_arb.sv
// Directed self-checking bench for rf_wen_arb with default parameters.
// Expected outputs are queued at drive time and checked after the edge.
module tb_rf_wen_arb;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        p0_valid;
    logic [3:0]  p0_addr;
    logic        p0_ready;
    logic        p1_valid;
    logic [3:0]  p1_addr;
    logic        p1_ready;
    logic [15:0] lock_mask;
    logic [15:0] R_en;
    logic [1:0]  wr_src;
    logic        drop_err;
    logic        hold_busy;

    typedef struct packed {
        logic [15:0] ren;
        logic [1:0]  src;
        logic        drop;
    } exp_t;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;

    rf_wen_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .p0_valid  (p0_valid),
        .p0_addr   (p0_addr),
        .p0_ready  (p0_ready),
        .p1_valid  (p1_valid),
        .p1_addr   (p1_addr),
        .p1_ready  (p1_ready),
        .lock_mask (lock_mask),
        .R_en      (R_en),
        .wr_src    (wr_src),
        .drop_err  (drop_err),
        .hold_busy (hold_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rdy(input string tag, input logic r0,
                           input logic r1, input logic busy);
        chk({tag, ".p0_ready"}, 32'(p0_ready), 32'(r0));
        chk({tag, ".p1_ready"}, 32'(p1_ready), 32'(r1));
        chk({tag, ".hold_busy"}, 32'(hold_busy), 32'(busy));
    endtask

    // One clock: drive, queue the expectation, then compare after the edge.
    task automatic cyc(input string tag,
                       input logic v0, input logic [3:0] a0,
                       input logic v1, input logic [3:0] a1,
                       input logic [15:0] ren, input logic [1:0] src,
                       input logic drop);
        exp_t e;
        p0_valid = v0;
        p0_addr  = a0;
        p1_valid = v1;
        p1_addr  = a1;
        sb.push_back('{ren: ren, src: src, drop: drop});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".R_en"}, 32'(R_en), 32'(e.ren));
        chk({tag, ".wr_src"}, 32'(wr_src), 32'(e.src));
        chk({tag, ".drop_err"}, 32'(drop_err), 32'(e.drop));
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        en        = 1'b1;
        p0_valid  = 1'b1;
        p0_addr   = 4'd2;
        p1_valid  = 1'b1;
        p1_addr   = 4'd6;
        lock_mask = 16'h0000;

        // Reset with all inputs active
        repeat (3) @(posedge clk);
        #1;
        chk("rst.R_en", 32'(R_en), 32'h0);
        chk("rst.wr_src", 32'(wr_src), 32'h0);
        chk("rst.drop_err", 32'(drop_err), 32'h0);
        chk("rst.hold_busy", 32'(hold_busy), 32'h0);
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_rdy("post_rst", 1'b1, 1'b1, 1'b0);

        // Decode with rotation, including wrap of addr 15
        cyc("p0_a0", 1, 4'd0, 0, 4'd0, 16'h0002, 2'b01, 0);
        cyc("p0_a15", 1, 4'd15, 0, 4'd0, 16'h0001, 2'b01, 0);
        cyc("idle0", 0, 4'd0, 0, 4'd0, 16'h0000, 2'b00, 0);
        cyc("p1_a15", 0, 4'd0, 1, 4'd15, 16'h0001, 2'b10, 0);

        // Collision: p0 first, p1 parked then issued
        cyc("col0", 1, 4'd3, 1, 4'd5, 16'h0010, 2'b01, 0);
        chk_rdy("col0", 1'b1, 1'b0, 1'b1);
        cyc("col1", 0, 4'd0, 0, 4'd0, 16'h0040, 2'b10, 0);
        chk_rdy("col1", 1'b1, 1'b1, 1'b0);

        // Starvation: forced hold grant on 4th cycle after capture
        cyc("stv0", 1, 4'd1, 1, 4'd9, 16'h0004, 2'b01, 0);
        cyc("stv1", 1, 4'd2, 0, 4'd0, 16'h0008, 2'b01, 0);
        cyc("stv2", 1, 4'd4, 0, 4'd0, 16'h0020, 2'b01, 0);
        chk_rdy("stv2", 1'b1, 1'b0, 1'b1);
        cyc("stv3", 1, 4'd6, 0, 4'd0, 16'h0080, 2'b01, 0);
        chk_rdy("stv3", 1'b0, 1'b0, 1'b1);
        cyc("stv4", 1, 4'd8, 0, 4'd0, 16'h0400, 2'b10, 0);
        chk_rdy("stv4", 1'b1, 1'b1, 1'b0);
        cyc("stv5", 1, 4'd8, 0, 4'd0, 16'h0200, 2'b01, 0);

        // Lock: consumed, flagged, not written
        lock_mask = 16'h0100;
        cyc("lock0", 0, 4'd0, 1, 4'd7, 16'h0000, 2'b10, 1);
        chk_rdy("lock0", 1'b1, 1'b1, 1'b0);
        cyc("lock1", 0, 4'd0, 0, 4'd0, 16'h0000, 2'b00, 0);
        cyc("lock2", 0, 4'd0, 1, 4'd6, 16'h0080, 2'b10, 0);
        lock_mask = 16'h0000;

        // en low freezes hold and its age
        cyc("en0", 1, 4'd0, 1, 4'd2, 16'h0002, 2'b01, 0);
        cyc("en1", 1, 4'd1, 0, 4'd0, 16'h0004, 2'b01, 0);
        en = 1'b0;
        cyc("en2", 1, 4'd3, 0, 4'd0, 16'h0000, 2'b00, 0);
        chk_rdy("en2", 1'b0, 1'b0, 1'b1);
        cyc("en3", 1, 4'd3, 1, 4'd9, 16'h0000, 2'b00, 0);
        en = 1'b1;
        cyc("en4", 1, 4'd3, 0, 4'd0, 16'h0010, 2'b01, 0);
        chk_rdy("en4", 1'b1, 1'b0, 1'b1);
        cyc("en5", 1, 4'd4, 0, 4'd0, 16'h0020, 2'b01, 0);
        chk_rdy("en5", 1'b0, 1'b0, 1'b1);
        cyc("en6", 1, 4'd5, 0, 4'd0, 16'h0008, 2'b10, 0);

        // Reset mid-hold discards the held write
        cyc("rh0", 1, 4'd0, 1, 4'd10, 16'h0002, 2'b01, 0);
        chk_rdy("rh0", 1'b1, 1'b0, 1'b1);
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rh.async.R_en", 32'(R_en), 32'h0);
        chk("rh.async.hold_busy", 32'(hold_busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("rh1", 0, 4'd0, 0, 4'd0, 16'h0000, 2'b00, 0);
        cyc("rh2", 0, 4'd0, 0, 4'd0, 16'h0000, 2'b00, 0);
        cyc("rh3", 0, 4'd0, 0, 4'd0, 16'h0000, 2'b00, 0);
        chk_rdy("rh3", 1'b1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_wen_arb.md
# rf_wen_arb

Parametrised register-file write-enable generator with two write ports, sitting between the execute/writeback stages and the register file. It converts an incoming register index into a one-hot, rotated write-enable vector and arbitrates two write ports (ALU writeback and load writeback). A one-entry holding buffer, an anti-starvation counter and a per-register write-lock mask sit behind a registered output stage.

## Interface
- `ADDR_W`, default 4: register index width.
- `NREG`, default 2**ADDR_W: number of registers and width of the enable vector.
- `ROT`, default 1: index-to-bit rotation; index i drives bit (i+ROT) mod NREG.
- `MAX_WAIT`, default 3: cycles the held port-1 write may wait before it overrides port 0.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: global enable; when low there are no grants, both readies are low and all state holds.
- `p0_valid` in 1: port-0 (ALU) write request.
- `p0_addr` in ADDR_W: port-0 register index.
- `p0_ready` out 1: port-0 accept.
- `p1_valid` in 1: port-1 (load) write request.
- `p1_addr` in ADDR_W: port-1 register index.
- `p1_ready` out 1: port-1 accept.
- `lock_mask` in NREG: a 1 write-protects that register bit, sampled in the grant cycle.
- `R_en` out NREG: registered one-hot write enable.
- `wr_src` out 2: registered source of the current `R_en`; 00 none, 01 p0, 10 p1.
- `drop_err` out 1: registered one-cycle pulse when a granted write hit a locked bit.
- `hold_busy` out 1: holding buffer occupied.

## Operation
- Decode: bit index = (addr + ROT) mod NREG, computed at ADDR_W+1 bits then wrapped. With defaults, addr 0 maps to bit 1, addr 14 to bit 15, addr 15 to bit 0.
- Readiness:
  - `p0_ready = en & ~(hold_busy & wait_cnt==MAX_WAIT)`.
  - `p1_ready = en & ~hold_busy`.
- A transfer occurs when valid and ready are both high. At most one grant per cycle.
- Grant priority when `en` is high:
  - Forced hold: if hold is valid and `wait_cnt==MAX_WAIT`, the hold entry is granted.
  - Otherwise port 0, if `p0_valid`.
  - Otherwise the hold entry, if valid.
  - Otherwise port 1, if `p1_valid & p1_ready`.
- Hold fill: if port 1 transfers in a cycle where it is not granted (port 0 won), its index is captured into the hold buffer. The hold buffer is never written while busy, because `p1_ready` is low.
- Hold state:
  - `wait_cnt` increments (saturating at MAX_WAIT) each cycle the hold is valid and not granted.
  - `wait_cnt` clears on hold grant.
  - The hold buffer empties on grant.
- Same-register collision (p0 and p1 target the same index in one cycle): p0 writes first and p1 writes one or more cycles later, so the later value wins. No merging.
- Lock: if a granted write's decoded bit is set in `lock_mask`, the request is consumed, `R_en` is all zero, `wr_src` still shows the source, and `drop_err` pulses.
- With no grant: `R_en`=0, `wr_src`=00, `drop_err`=0.

## Timing
- Latency: grant in cycle N, `R_en`/`wr_src`/`drop_err` valid in cycle N+1 for exactly one cycle.
- Reset (asynchronous assert, synchronous release): `R_en`=0, `wr_src`=00, `drop_err`=0, hold empty, `hold_busy`=0, `wait_cnt`=0.
- After reset, `p0_ready` and `p1_ready` equal `en`.
- Reset mid-hold: the held write is discarded and is never issued.
- `en` falling while hold is busy: the hold entry and `wait_cnt` are frozen and resume when `en` returns. Outputs read zero the cycle after `en` goes low.
- Readies are combinational from registered state and `en` only. There is no path from valid to ready.

## Structure
- Package `rf_pkg`:
  - `wr_src_t` enum (NONE, P0, P1).
  - Function `rot_idx(addr, ROT, NREG)`.
  - Default localparams.
- Sub-module `rf_onehot_dec`: parametrised combinational index-to-one-hot rotated decoder, instantiated once on the granted index.
- Top level contains the grant mux, hold register, `wait_cnt` and the output register.

## Test plan
- Reset with all inputs active: outputs zero during reset; the first cycle after release has `p0_ready`=`p1_ready`=1.
- p0 addr 0, then addr 15 (defaults): `R_en`=0x0002, then 0x0001, each one cycle after grant; `wr_src`=01.
- Collision, p0 addr 3 and p1 addr 5 in the same cycle:
  - Cycle +1: `R_en`=0x0010, `wr_src`=01, `hold_busy`=1, `p1_ready`=0.
  - Cycle +2: `R_en`=0x0040, `wr_src`=10.
- Starvation, MAX_WAIT=3, p0 valid every cycle with a hold pending: hold granted on the 4th cycle after capture, with `p0_ready`=0 that cycle. p0 resumes the following cycle.
- Lock, `lock_mask`=0x0100 with p1 addr 7: `R_en`=0, `wr_src`=10, `drop_err`=1 for one cycle, request consumed.
- Reset asserted while `hold_busy`=1, then released with no traffic: the held write never appears on `R_en`.
